// File: rtl/cache_controller_pkg.sv
// Shared types and constants for the L1 cache protocol controller and its storage array.
package cache_controller_pkg;

  localparam int SETS     = 16384;
  localparam int WAYS     = 8;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 6;
  localparam int TAG_W    = 12;
  localparam int LRU_W    = 3;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_t;
  typedef enum logic [1:0] {BUS_READ, BUS_WRITE, BUS_INVALIDATE, BUS_RWIM} bus_op_t;
  typedef enum logic [1:0] {SNOOP_NOHIT, SNOOP_HIT, SNOOP_HITM} snoop_t;

  typedef struct packed {
    logic [3:0]        n;
    logic [ADDR_W-1:0] address;
  } command_t;

  typedef struct packed {
    mesi_t             mesi;
    logic [LRU_W-1:0]  lru;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cache_line_t;

  typedef cache_line_t [WAYS-1:0] cache_set_t;

  localparam logic [3:0] CMD_READ         = 4'd0;
  localparam logic [3:0] CMD_WRITE        = 4'd1;
  localparam logic [3:0] CMD_FETCH        = 4'd2;
  localparam logic [3:0] CMD_SNOOP_READ   = 4'd3;
  localparam logic [3:0] CMD_SNOOP_WRITE  = 4'd4;
  localparam logic [3:0] CMD_SNOOP_RWIM   = 4'd5;
  localparam logic [3:0] CMD_SNOOP_INVAL  = 4'd6;
  localparam logic [3:0] CMD_CLEAR        = 4'd8;
  localparam logic [3:0] CMD_PRINT        = 4'd9;

endpackage

// File: rtl/cache_controller_if.sv
// Trace-command and bus handshake bundle between the controller (master) and its environment (slave).
interface cache_controller_if;
  import cache_controller_pkg::*;

  // A transfer happens on a clock edge where valid and ready are both 1; the
  // valid side holds its payload stable and keeps valid high until that edge.
  logic     cmd_valid;
  logic     cmd_ready;
  command_t cmd;
  logic     bus_valid;
  bus_op_t  bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic     bus_ready;
  snoop_t   bus_snoop_in;

  modport master (
    input  cmd_valid, cmd, bus_ready, bus_snoop_in,
    output cmd_ready, bus_valid, bus_op, bus_addr
  );

  modport slave (
    output cmd_valid, cmd, bus_ready, bus_snoop_in,
    input  cmd_ready, bus_valid, bus_op, bus_addr
  );
endinterface

// File: rtl/cache_controller_lru_update.sv
// Victim selection and LRU recency update for one set; purely combinational.
module lru_update
  import cache_controller_pkg::*;
#(
    parameter int ways  = WAYS,
    parameter int WAY_W = $clog2(ways)
) (
    input  cache_line_t [ways-1:0]            set_in,
    input  logic        [WAY_W-1:0]           way,
    output logic        [ways-1:0][LRU_W-1:0] lru_out,
    output logic        [WAY_W-1:0]           victim
);

  logic [LRU_W-1:0] old_lru;
  logic [WAY_W-1:0] victim_lru;
  logic [WAY_W-1:0] victim_inv;
  logic             has_inv;

  always_comb begin
    old_lru = set_in[way].lru;
    for (int w = 0; w < ways; w++) begin
      if (WAY_W'(w) == way)
        lru_out[w] = LRU_W'(ways - 1);
      else if (set_in[w].lru > old_lru)
        lru_out[w] = set_in[w].lru - 1'b1;
      else
        lru_out[w] = set_in[w].lru;
    end
  end

  // Descending scan so the lowest-index candidate is the one left standing.
  always_comb begin
    victim_lru = '0;
    victim_inv = '0;
    has_inv    = 1'b0;
    for (int w = ways - 1; w >= 0; w--) begin
      if (set_in[w].lru == '0) victim_lru = WAY_W'(w);
      if (set_in[w].mesi == MESI_I) begin
        victim_inv = WAY_W'(w);
        has_inv    = 1'b1;
      end
    end
    victim = has_inv ? victim_inv : victim_lru;
  end

endmodule

// File: rtl/cache_controller.sv
// MESI protocol controller: reads a set, resolves hit/miss/snoop, runs bus operations, writes the set back.
module cache_controller
  import cache_controller_pkg::*;
#(
    parameter int sets  = SETS,
    parameter int ways  = WAYS,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cache_controller_if.master      link,
    output command_t                arr_instruction,
    output logic                    arr_read_enable,
    output logic                    arr_write_enable,
    input  cache_line_t [ways-1:0]  arr_cache_out,
    output cache_line_t [ways-1:0]  arr_cache_in,
    output snoop_t                  snoop_result,
    output logic                    snoop_valid,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count,
    output logic [CNT_W-1:0]        read_count,
    output logic [CNT_W-1:0]        write_count,
    output logic [2:0]              dbg_state
);

  localparam int WAY_W      = $clog2(ways);
  localparam int INDEX_BITS = $clog2(sets);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_EVAL   = 3'd2;
  localparam logic [2:0] S_BUS_WB = 3'd3;
  localparam logic [2:0] S_BUS_OP = 3'd4;
  localparam logic [2:0] S_WR     = 3'd5;
  localparam logic [2:0] S_PASS   = 3'd6;

  logic [2:0]        state;
  command_t          cmd_q;
  bus_op_t           op_q;
  logic              need_op_q;
  logic              fill_q;
  logic [WAY_W-1:0]  fill_way_q;
  logic [ADDR_W-1:0] op_addr_q;
  logic [ADDR_W-1:0] wb_addr_q;

  logic [TAG_W-1:0]      cmd_tag;
  logic [INDEX_BITS-1:0] cmd_index;
  logic [ADDR_W-1:0]     cmd_line;
  logic                  is_proc;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      victim;
  logic [WAY_W-1:0]      access_way;
  logic [ways-1:0][LRU_W-1:0] lru_new;

  cache_line_t [ways-1:0] next_set;
  mesi_t             hit_mesi;
  logic              eval_wb;
  logic [ADDR_W-1:0] eval_wb_addr;
  logic              eval_op_valid;
  bus_op_t           eval_op;
  logic              eval_fill;
  snoop_t            eval_snoop;

  assign cmd_tag   = cmd_q.address[ADDR_W-1 -: TAG_W];
  assign cmd_index = cmd_q.address[OFFSET_W +: INDEX_BITS];
  assign cmd_line  = {cmd_q.address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign is_proc   = (cmd_q.n == CMD_READ) || (cmd_q.n == CMD_WRITE) || (cmd_q.n == CMD_FETCH);

  assign link.cmd_ready   = (state == S_IDLE);
  assign link.bus_valid   = (state == S_BUS_WB) || (state == S_BUS_OP);
  assign link.bus_op      = (state == S_BUS_WB) ? BUS_WRITE : (state == S_BUS_OP) ? op_q : BUS_READ;
  assign link.bus_addr    = (state == S_BUS_WB) ? wb_addr_q : (state == S_BUS_OP) ? op_addr_q : '0;
  assign arr_instruction  = cmd_q;
  assign arr_read_enable  = (state == S_RD);
  assign arr_write_enable = (state == S_WR);
  assign dbg_state        = state;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = ways - 1; w >= 0; w--) begin
      if (arr_cache_out[w].tag == cmd_tag && arr_cache_out[w].mesi != MESI_I) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign access_way = hit ? hit_way : victim;

  lru_update #(.ways(ways), .WAY_W(WAY_W)) u_lru (
    .set_in  (arr_cache_out),
    .way     (access_way),
    .lru_out (lru_new),
    .victim  (victim)
  );

  always_comb begin
    next_set      = arr_cache_out;
    hit_mesi      = arr_cache_out[hit_way].mesi;
    eval_wb       = 1'b0;
    eval_wb_addr  = cmd_line;
    eval_op_valid = 1'b0;
    eval_op       = BUS_READ;
    eval_fill     = 1'b0;
    eval_snoop    = SNOOP_NOHIT;
    if (is_proc) begin
      for (int w = 0; w < ways; w++) next_set[w].lru = lru_new[w];
      if (hit) begin
        if (cmd_q.n == CMD_WRITE) begin
          next_set[hit_way].mesi = MESI_M;
          if (hit_mesi == MESI_S) begin
            eval_op_valid = 1'b1;
            eval_op       = BUS_INVALIDATE;
          end
        end
      end else begin
        // Fill the victim; a dirty victim is written back before the fill op.
        next_set[victim].tag  = cmd_tag;
        next_set[victim].data = '0;
        eval_op_valid = 1'b1;
        eval_wb       = (arr_cache_out[victim].mesi == MESI_M);
        eval_wb_addr  = {arr_cache_out[victim].tag, cmd_index, {OFFSET_W{1'b0}}};
        if (cmd_q.n == CMD_WRITE) begin
          next_set[victim].mesi = MESI_M;
          eval_op               = BUS_RWIM;
        end else begin
          next_set[victim].mesi = MESI_E;
          eval_op               = BUS_READ;
          eval_fill             = 1'b1;
        end
      end
    end else if (hit) begin
      eval_snoop = (hit_mesi == MESI_M) ? SNOOP_HITM : SNOOP_HIT;
      case (cmd_q.n)
        CMD_SNOOP_READ: begin
          if (hit_mesi == MESI_M || hit_mesi == MESI_E) next_set[hit_way].mesi = MESI_S;
          eval_wb = (hit_mesi == MESI_M);
        end
        CMD_SNOOP_RWIM: begin
          next_set[hit_way].mesi = MESI_I;
          eval_wb = (hit_mesi == MESI_M);
        end
        CMD_SNOOP_INVAL: begin
          if (hit_mesi == MESI_S) next_set[hit_way].mesi = MESI_I;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cmd_q        <= '0;
      op_q         <= BUS_READ;
      need_op_q    <= 1'b0;
      fill_q       <= 1'b0;
      fill_way_q   <= '0;
      op_addr_q    <= '0;
      wb_addr_q    <= '0;
      arr_cache_in <= '0;
      snoop_result <= SNOOP_NOHIT;
      snoop_valid  <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
      read_count   <= '0;
      write_count  <= '0;
    end else begin
      snoop_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (link.cmd_valid) begin
            cmd_q <= link.cmd;
            if (link.cmd.n == CMD_CLEAR || link.cmd.n == CMD_PRINT) state <= S_PASS;
            else if (link.cmd.n <= CMD_SNOOP_INVAL)                   state <= S_RD;
          end
        end
        S_RD: state <= S_EVAL;
        S_EVAL: begin
          arr_cache_in <= next_set;
          op_q         <= eval_op;
          need_op_q    <= eval_op_valid;
          fill_q       <= eval_fill;
          fill_way_q   <= victim;
          op_addr_q    <= cmd_line;
          wb_addr_q    <= eval_wb_addr;
          if (is_proc) begin
            if (hit) hit_count  <= sat_inc(hit_count);
            else     miss_count <= sat_inc(miss_count);
            if (cmd_q.n == CMD_WRITE) write_count <= sat_inc(write_count);
            else                      read_count  <= sat_inc(read_count);
          end else begin
            snoop_result <= eval_snoop;
            snoop_valid  <= 1'b1;
          end
          if (eval_wb)            state <= S_BUS_WB;
          else if (eval_op_valid) state <= S_BUS_OP;
          else                    state <= S_WR;
        end
        S_BUS_WB: begin
          if (link.bus_ready) state <= need_op_q ? S_BUS_OP : S_WR;
        end
        S_BUS_OP: begin
          if (link.bus_ready) begin
            if (fill_q)
              arr_cache_in[fill_way_q].mesi <= (link.bus_snoop_in == SNOOP_NOHIT) ? MESI_E : MESI_S;
            state <= S_WR;
          end
        end
        S_WR: state <= S_IDLE;
        S_PASS: begin
          if (cmd_q.n == CMD_CLEAR) begin
            hit_count   <= '0;
            miss_count  <= '0;
            read_count  <= '0;
            write_count <= '0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural storage array and bus responder.
module tb_cache_controller;
  import cache_controller_pkg::*;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_controller_if link();

  command_t                arr_instruction;
  logic                    arr_read_enable;
  logic                    arr_write_enable;
  cache_line_t [WAYS-1:0]  arr_cache_out;
  cache_line_t [WAYS-1:0]  arr_cache_in;
  snoop_t                  snoop_result;
  logic                    snoop_valid;
  logic [CNT_W-1:0]        hit_count, miss_count, read_count, write_count;
  logic [2:0]              dbg_state;

  cache_controller #(.sets(SETS), .ways(WAYS), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .link             (link),
    .arr_instruction  (arr_instruction),
    .arr_read_enable  (arr_read_enable),
    .arr_write_enable (arr_write_enable),
    .arr_cache_out    (arr_cache_out),
    .arr_cache_in     (arr_cache_in),
    .snoop_result     (snoop_result),
    .snoop_valid      (snoop_valid),
    .hit_count        (hit_count),
    .miss_count       (miss_count),
    .read_count       (read_count),
    .write_count      (write_count),
    .dbg_state        (dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [33:0] exp_q[$];
  int ready_delay = 0;
  int wait_cnt = 0;
  int held_cycles = 0;
  int snoop_seen = 0;
  snoop_t last_snoop = SNOOP_NOHIT;
  cache_set_t mem [int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cache_set_t get_set(input int idx);
    cache_set_t s;
    if (mem.exists(idx)) return mem[idx];
    for (int w = 0; w < WAYS; w++) begin
      s[w].mesi = MESI_I;
      s[w].lru  = LRU_W'(w);
      s[w].tag  = '0;
      s[w].data = '0;
    end
    return s;
  endfunction

  function automatic cache_line_t line_of(input int idx, input int w);
    cache_set_t s;
    s = get_set(idx);
    return s[w];
  endfunction

  // Storage array: registered read, write on the enable edge.
  initial arr_cache_out = '0;
  always @(posedge clk) begin
    if (arr_read_enable) arr_cache_out <= get_set(int'(arr_instruction.address[19:6]));
    if (arr_write_enable) mem[int'(arr_instruction.address[19:6])] = arr_cache_in;
  end

  // Bus responder: compares each cycle of a pending op against the scoreboard head.
  initial link.bus_ready = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      link.bus_ready = 1'b0;
      wait_cnt = 0;
    end else if (link.bus_ready) begin
      link.bus_ready = 1'b0;
      wait_cnt = 0;
    end else if (link.bus_valid) begin
      check("bus_expected_present", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("bus_op_addr", 64'({2'(link.bus_op), link.bus_addr}), 64'(exp_q[0]));
        if (wait_cnt >= ready_delay) begin
          link.bus_ready = 1'b1;
          void'(exp_q.pop_front());
        end else begin
          wait_cnt++;
          held_cycles++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (snoop_valid) begin
      snoop_seen++;
      last_snoop = snoop_result;
    end
  end

  task automatic start_cmd(input logic [3:0] n, input logic [31:0] addr);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!link.cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_accept_timeout", 64'(guard < 100), 64'd1);
    link.cmd_valid = 1'b1;
    link.cmd.n = n;
    link.cmd.address = addr;
    @(negedge clk);
    link.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!link.cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_done_timeout", 64'(guard < 200), 64'd1);
  endtask

  task automatic do_cmd(input logic [3:0] n, input logic [31:0] addr);
    start_cmd(n, addr);
    wait_idle();
  endtask

  function automatic logic [33:0] bus_exp(input bus_op_t op, input logic [31:0] addr);
    return {2'(op), addr};
  endfunction

  logic [31:0] a_t;
  int held_before;
  int snoops_before;

  initial begin
    rst_n = 1'b0;
    link.cmd_valid = 1'b0;
    link.cmd = '0;
    link.bus_snoop_in = SNOOP_NOHIT;
    #1;
    check("rst_cmd_ready", 64'(link.cmd_ready), 64'd1);
    check("rst_bus_valid", 64'(link.bus_valid), 64'd0);
    check("rst_bus_op", 64'(link.bus_op), 64'(BUS_READ));
    check("rst_rd_en", 64'(arr_read_enable), 64'd0);
    check("rst_wr_en", 64'(arr_write_enable), 64'd0);
    check("rst_cache_in_zero", 64'(arr_cache_in == '0), 64'd1);
    check("rst_snoop_valid", 64'(snoop_valid), 64'd0);
    check("rst_counters", 64'(hit_count | miss_count | read_count | write_count), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Read miss into an empty set, other caches miss.
    exp_q.push_back(bus_exp(BUS_READ, 32'h40));
    do_cmd(CMD_READ, 32'h0000_0040);
    check("rd_miss_mesi", 64'(line_of(1, 0).mesi), 64'(MESI_E));
    check("rd_miss_lru_way0", 64'(line_of(1, 0).lru), 64'd7);
    check("rd_miss_lru_way1", 64'(line_of(1, 1).lru), 64'd0);
    check("rd_miss_lru_way7", 64'(line_of(1, 7).lru), 64'd6);
    check("rd_miss_count", 64'(miss_count), 64'd1);
    check("rd_read_count", 64'(read_count), 64'd1);

    // Write hit on E: silent upgrade to M.
    do_cmd(CMD_WRITE, 32'h0000_0040);
    check("wr_hit_mesi", 64'(line_of(1, 0).mesi), 64'(MESI_M));
    check("wr_hit_count", 64'(hit_count), 64'd1);
    check("wr_write_count", 64'(write_count), 64'd1);

    // Fill the rest of set 1; tag 3 is shared elsewhere.
    for (int t = 1; t < 8; t++) begin
      a_t = (32'(t) << 20) | 32'h40;
      link.bus_snoop_in = (t == 3) ? SNOOP_HIT : SNOOP_NOHIT;
      exp_q.push_back(bus_exp(BUS_READ, a_t));
      do_cmd(CMD_READ, a_t);
    end
    link.bus_snoop_in = SNOOP_NOHIT;
    check("fill_way3_shared", 64'(line_of(1, 3).mesi), 64'(MESI_S));
    check("fill_way5_tag", 64'(line_of(1, 5).tag), 64'd5);
    check("fill_way0_lru", 64'(line_of(1, 0).lru), 64'd0);

    // Ninth tag evicts the dirty LRU way: WRITE then READ, each stalled 3 cycles.
    ready_delay = 3;
    held_before = held_cycles;
    exp_q.push_back(bus_exp(BUS_WRITE, 32'h0000_0040));
    exp_q.push_back(bus_exp(BUS_READ, 32'h0080_0040));
    do_cmd(CMD_READ, 32'h0080_0040);
    ready_delay = 0;
    check("evict_held_cycles", 64'(held_cycles - held_before), 64'd6);
    check("evict_way0_tag", 64'(line_of(1, 0).tag), 64'd8);
    check("evict_way0_mesi", 64'(line_of(1, 0).mesi), 64'(MESI_E));
    check("evict_way0_lru", 64'(line_of(1, 0).lru), 64'd7);
    check("evict_way1_lru", 64'(line_of(1, 1).lru), 64'd0);
    check("evict_way7_lru", 64'(line_of(1, 7).lru), 64'd6);

    // Write hit on S needs an INVALIDATE.
    exp_q.push_back(bus_exp(BUS_INVALIDATE, 32'h0030_0040));
    do_cmd(CMD_WRITE, 32'h0030_0040);
    check("wr_s_mesi", 64'(line_of(1, 3).mesi), 64'(MESI_M));

    // Make tag 1 Modified, then snoop it.
    do_cmd(CMD_WRITE, 32'h0010_0040);
    check("wr_e_to_m", 64'(line_of(1, 1).mesi), 64'(MESI_M));
    snoops_before = snoop_seen;
    exp_q.push_back(bus_exp(BUS_WRITE, 32'h0010_0040));
    do_cmd(CMD_SNOOP_READ, 32'h0010_0040);
    check("snp_rd_pulse", 64'(snoop_seen - snoops_before), 64'd1);
    check("snp_rd_result", 64'(last_snoop), 64'(SNOOP_HITM));
    check("snp_rd_mesi", 64'(line_of(1, 1).mesi), 64'(MESI_S));
    do_cmd(CMD_SNOOP_INVAL, 32'h0010_0040);
    check("snp_inv_result", 64'(last_snoop), 64'(SNOOP_HIT));
    check("snp_inv_mesi", 64'(line_of(1, 1).mesi), 64'(MESI_I));
    do_cmd(CMD_SNOOP_READ, 32'h0000_0040);
    check("snp_absent_result", 64'(last_snoop), 64'(SNOOP_NOHIT));

    // Write miss uses RWIM.
    exp_q.push_back(bus_exp(BUS_RWIM, 32'h0000_00C0));
    do_cmd(CMD_WRITE, 32'h0000_00C0);
    check("wr_miss_mesi", 64'(line_of(3, 0).mesi), 64'(MESI_M));
    check("stat_hits", 64'(hit_count), 64'd3);
    check("stat_misses", 64'(miss_count), 64'd10);
    check("stat_reads", 64'(read_count), 64'd9);
    check("stat_writes", 64'(write_count), 64'd4);

    // Reset while the READ sits in BUS_OP.
    ready_delay = 50;
    exp_q.push_back(bus_exp(BUS_READ, 32'h80));
    start_cmd(CMD_READ, 32'h0000_0080);
    for (int g = 0; g < 20 && !link.bus_valid; g++) @(negedge clk);
    check("pre_rst_bus_valid", 64'(link.bus_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bus_valid", 64'(link.bus_valid), 64'd0);
    check("mid_rst_cmd_ready", 64'(link.cmd_ready), 64'd1);
    check("mid_rst_wr_en", 64'(arr_write_enable), 64'd0);
    check("mid_rst_cache_in", 64'(arr_cache_in == '0), 64'd1);
    check("mid_rst_miss_count", 64'(miss_count), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    ready_delay = 0;
    check("rst_no_array_write", 64'(mem.exists(2)), 64'd0);
    exp_q.push_back(bus_exp(BUS_READ, 32'h80));
    do_cmd(CMD_READ, 32'h0000_0080);
    check("post_rst_way0_lru", 64'(line_of(2, 0).lru), 64'd7);
    check("post_rst_way1_lru", 64'(line_of(2, 1).lru), 64'd0);
    check("post_rst_miss_count", 64'(miss_count), 64'd1);

    // Clear passes through to the array and zeroes statistics.
    start_cmd(CMD_CLEAR, 32'h0);
    check("clear_arr_n", 64'(arr_instruction.n), 64'd8);
    check("clear_no_read", 64'(arr_read_enable), 64'd0);
    wait_idle();
    check("clear_counters", 64'(hit_count | miss_count | read_count | write_count), 64'd0);

    // Unused code is dropped in IDLE.
    start_cmd(4'd7, 32'h40);
    check("drop_cmd_ready", 64'(link.cmd_ready), 64'd1);
    check("drop_no_read", 64'(arr_read_enable), 64'd0);
    @(negedge clk);
    check("drop_state", 64'(dbg_state), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
